fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
// - Forwarding/hazard controller for the 5-stage 16-bit pipeline; drives the sel inputs of both EX-stage fwd_mux instances.
// - Tracks destination regs of in-flight instrs in internal shadow regs (ID/EX, EX/MEM, MEM/WB).
// - Resolves forward source one cycle early (in ID); registers sels so they are valid while the consumer is in EX.
// - Detects load-use hazards and requests a 1-cycle IF/ID stall with a bubble into EX.
// PARAMETERS
// - REG_AW   4   register index width (16 GPRs)
// - CNT_W    16  width of statistics counters (used only with FWD_STATS_EN)
// - R0_ZERO  1   1: register 0 is hardwired zero, never forwarded, never causes stall
// PORTS
// - clk           in   1      core clock, all state on rising edge
// - rst_n         in   1      asynchronous active-low reset
// - ext_stall     in   1      global pipeline freeze (memory stall); holds all state
// - flush         in   1      squash instr currently in ID (taken branch/jump)
// - id_valid      in   1      ID holds a real instruction
// - id_rs         in   REG_AW source A index;       id_rs_used  in 1  src A read by instr
// - id_rt         in   REG_AW source B index;       id_rt_used  in 1  src B read by instr
// - id_rd         in   REG_AW destination index;    id_we       in 1  instr writes RF
// - id_is_load    in   1      instr is LW (result available only after MEM)
// - fwd_sel_a     out  2      sel for ALU A fwd_mux: 00 RF, 01 EX2EX, 10 MEM2EX
// - fwd_sel_b     out  2      sel for ALU B fwd_mux, same encoding
// - hazard_stall  out  1      comb.: hold PC and IF/ID this cycle, insert bubble
// - ex_valid      out  1      ID/EX shadow valid (debug/visibility)
// BEHAVIOUR
// - Shadow entry = {valid, we, is_load, rd}. Entries SH_EX (ID/EX), SH_MEM (EX/MEM), SH_WB (MEM/WB).
// - Reset: all shadows invalid, fwd_sel_a/b = 00, ex_valid = 0, hazard_stall = 0, counters = 0.
// - Write-match m(S,r): S.valid & S.we & S.rd==r & !(R0_ZERO & r==0).
// - Source A needed: nA = id_valid & id_rs_used; likewise nB with id_rt.
// - Load-use: hazard_stall = (nA & m(SH_EX,id_rs) | nB & m(SH_EX,id_rt)) & SH_EX.is_load. Comb., ignores ext_stall/flush.
// - Next sel for a source (priority high->low): m(SH_EX,r) & !is_load -> 01; m(SH_MEM,r) -> 10; else 00.
// - Clock edge, priority ext_stall > flush > hazard_stall > normal:
//   - ext_stall=1: all shadows, sels, counters hold.
//   - flush=1: SH_EX <= bubble, sels <= 00; SH_MEM<=SH_EX, SH_WB<=SH_MEM advance; stall discarded.
//   - hazard_stall=1: same as flush (bubble into EX, sels 00); IF/ID held externally.
//   - normal: SH_EX <= {id_valid,id_we,id_is_load,id_rd}, sels <= computed; others advance.
// - Latency: dependency seen in ID -> sel valid next cycle (consumer in EX). Stall exactly 1 cycle per
//   load-use; after bubble the load sits in SH_MEM -> consumer gets 10.
// - Back-to-back writers to same rd: youngest (SH_EX) wins -> 01.
// - SH_WB participates only in advance; RF write-before-read covers 3-ahead producers (no sel).
// - id_valid=0 or *_used=0: sel 00, no stall for that source.
// - Reset asserted mid-operation: immediate async clear of all state, no partial-cycle outputs.
// CONFIGURATION
// - Macro FWD_STATS_EN defined: extra outputs stat_stall_cnt[CNT_W-1:0], stat_fwd_cnt[CNT_W-1:0].
//   - stall_cnt +1 per cycle with hazard_stall=1 & ext_stall=0 & flush=0.
//   - fwd_cnt +1 per non-stalled, non-flushed, non-ext_stall edge where a loaded sel != 00
//     (+1 max per edge, even if both sels non-zero).
//   - Counters saturate at all-ones; reset to 0 only by rst_n.
// - Not defined: counter ports and logic absent; all other behaviour identical.
// TESTING
// - ADD R1 then ADD R2,R1,R3 (consecutive) -> cycle consumer in EX: fwd_sel_a=01, sel_b=00, no stall.
// - ADD R1; NOP; SUB R4,R5,R1 -> fwd_sel_b=10 when SUB in EX; no stall.
// - LW R2 then ADD R3,R2,R2 -> hazard_stall=1 exactly 1 cycle, bubble (sels 00, ex_valid=0), then sel_a=sel_b=10.
// - ADD R1; ADD R1; XOR R6,R1,R1 -> both sels 01 (youngest wins); write to R0 then read R0 -> 00.
// - LW R2 + dependent ADD with flush=1 same cycle -> no stall recorded, bubble; ext_stall=1 for 3 cycles
//   holds sels/shadows unchanged.
// - FWD_STATS_EN: above sequence -> stat_stall_cnt=1, stat_fwd_cnt=counted EX-forward events;
//   force 2^CNT_W events -> holds 0xFFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage 16-bit pipeline.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rs_used,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              hazard_stall,
    output logic              ex_valid
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_stall_cnt,
    output logic [CNT_W-1:0]  stat_fwd_cnt
`endif
);

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // ID/EX shadow; ex_valid doubles as its valid bit.
    logic              ex_we;
    logic              ex_ld;
    logic [REG_AW-1:0] ex_rd;
    // EX/MEM shadow. A MEM/WB producer is covered by RF write-before-read,
    // so nothing older than EX/MEM needs to be tracked.
    logic              mem_vld;
    logic              mem_we;
    logic [REG_AW-1:0] mem_rd;

    logic       need_a, need_b;
    logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic [1:0] sel_a_d, sel_b_d;
    logic       bubble;

    function automatic logic wr_match(input logic v, input logic we,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
        return v && we && (rd == r) && !(R0_ZERO && (r == '0));
    endfunction

    always_comb begin
        need_a    = id_valid & id_rs_used;
        need_b    = id_valid & id_rt_used;
        ex_hit_a  = need_a & wr_match(ex_valid, ex_we, ex_rd, id_rs);
        ex_hit_b  = need_b & wr_match(ex_valid, ex_we, ex_rd, id_rt);
        mem_hit_a = need_a & wr_match(mem_vld, mem_we, mem_rd, id_rs);
        mem_hit_b = need_b & wr_match(mem_vld, mem_we, mem_rd, id_rt);

        hazard_stall = ex_ld & (ex_hit_a | ex_hit_b);
        bubble       = flush | hazard_stall;

        sel_a_d = 2'b00;
        if (ex_hit_a && !ex_ld) begin
            sel_a_d = 2'b01;
        end else if (mem_hit_a) begin
            sel_a_d = 2'b10;
        end

        sel_b_d = 2'b00;
        if (ex_hit_b && !ex_ld) begin
            sel_b_d = 2'b01;
        end else if (mem_hit_b) begin
            sel_b_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_we     <= 1'b0;
            ex_ld     <= 1'b0;
            ex_rd     <= '0;
            mem_vld   <= 1'b0;
            mem_we    <= 1'b0;
            mem_rd    <= '0;
            fwd_sel_a <= 2'b00;
            fwd_sel_b <= 2'b00;
        end else if (!ext_stall) begin
            mem_vld <= ex_valid;
            mem_we  <= ex_we;
            mem_rd  <= ex_rd;
            if (bubble) begin
                ex_valid  <= 1'b0;
                ex_we     <= 1'b0;
                ex_ld     <= 1'b0;
                ex_rd     <= '0;
                fwd_sel_a <= 2'b00;
                fwd_sel_b <= 2'b00;
            end else begin
                ex_valid  <= id_valid;
                ex_we     <= id_we;
                ex_ld     <= id_is_load;
                ex_rd     <= id_rd;
                fwd_sel_a <= sel_a_d;
                fwd_sel_b <= sel_b_d;
            end
        end
    end

`ifdef FWD_STATS_EN
    // Both counters saturate; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else if (!ext_stall && !flush) begin
            if (hazard_stall) begin
                if (stat_stall_cnt != '1) begin
                    stat_stall_cnt <= stat_stall_cnt + CNT_W'(1);
                end
            end else if ((sel_a_d != 2'b00) || (sel_b_d != 2'b00)) begin
                if (stat_fwd_cnt != '1) begin
                    stat_fwd_cnt <= stat_fwd_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
